// File: rtl/ysyx_22040759_define.sv
// Shared definitions for the ysyx_22040759 load/store path: funct3 codes,
// LSU state encoding and byte-lane size masks.
package ysyx_22040759_define;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] store_size_mask(input logic [2:0] func3);
        case (func3)
            F3_SB:   store_size_mask = MASK_B;
            F3_SH:   store_size_mask = MASK_H;
            F3_SW:   store_size_mask = MASK_W;
            F3_SD:   store_size_mask = MASK_D;
            default: store_size_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Combinational lane logic: store mask/data shifting and misalignment on the
// accept side, load field extraction and extension on the return side.
module ysyx_22040759_lsu_align
    import ysyx_22040759_define::*;
(
    input  logic [2:0]  acc_func3_i,
    input  logic [2:0]  acc_off_i,
    input  logic [63:0] acc_wdata_i,
    output logic [7:0]  st_wmask_o,
    output logic [63:0] st_wdata_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_func3_i,
    input  logic [2:0]  ld_off_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] ld_shift;

    always_comb begin
        st_wmask_o = store_size_mask(acc_func3_i) << acc_off_i;
        st_wdata_o = acc_wdata_i << {acc_off_i, 3'b000};

        // Size lives in func3[1:0] for both loads and stores.
        case (acc_func3_i[1:0])
            2'b01:   misalign_o = acc_off_i[0];
            2'b10:   misalign_o = |acc_off_i[1:0];
            2'b11:   misalign_o = |acc_off_i;
            default: misalign_o = 1'b0;
        endcase
    end

    always_comb begin
        ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_func3_i)
            F3_LB:   ld_data_o = {{56{ld_shift[7]}},  ld_shift[7:0]};
            F3_LH:   ld_data_o = {{48{ld_shift[15]}}, ld_shift[15:0]};
            F3_LW:   ld_data_o = {{32{ld_shift[31]}}, ld_shift[31:0]};
            F3_LD:   ld_data_o = ld_shift;
            F3_LBU:  ld_data_o = {56'd0, ld_shift[7:0]};
            F3_LHU:  ld_data_o = {48'd0, ld_shift[15:0]};
            F3_LWU:  ld_data_o = {32'd0, ld_shift[31:0]};
            default: ld_data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_lsu.sv
// Multi-cycle RV64 load/store unit: request latch, memory handshake FSM,
// watchdog and result hold until write-back accepts.
//   state | meaning
//   IDLE  | ready for a new request
//   REQ   | mem_req high, waiting for mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid
//   DONE  | result / fault / timeout presented on out_*
module ysyx_22040759_lsu
    import ysyx_22040759_define::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TCNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_func3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_fault,
    output logic        out_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]       addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic              we_q, we_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              timeout_q, timeout_d;

    logic [7:0]  st_wmask;
    logic [63:0] st_wdata;
    logic        misalign;
    logic [63:0] ld_data;
    logic        acc_fault;

    ysyx_22040759_lsu_align u_align (
        .acc_func3_i (in_func3),
        .acc_off_i   (in_addr[2:0]),
        .acc_wdata_i (in_wdata),
        .st_wmask_o  (st_wmask),
        .st_wdata_o  (st_wdata),
        .misalign_o  (misalign),
        .ld_func3_i  (func3_q),
        .ld_off_i    (addr_q[2:0]),
        .ld_rdata_i  (mem_rdata),
        .ld_data_o   (ld_data)
    );

    assign acc_fault = (in_ren & in_wen)
                     | (in_ren & (in_func3 == 3'b111))
                     | (in_wen & in_func3[2])
                     | ((in_ren | in_wen) & misalign);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        func3_d   = func3_q;
        we_d      = we_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        timeout_d = timeout_q;

        case (state_q)
            LSU_IDLE: begin
                if (in_valid) begin
                    addr_d    = in_addr;
                    func3_d   = in_func3;
                    we_d      = in_wen;
                    wmask_d   = st_wmask;
                    wdata_d   = st_wdata;
                    rd_d      = in_rd;
                    rdata_d   = 64'd0;
                    fault_d   = acc_fault;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    if (acc_fault || (!in_ren && !in_wen)) begin
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + TCNT_W'(1);
                // A grant on the last watchdog cycle still completes normally.
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = LSU_DONE;
                    end else if (mem_rvalid) begin
                        rdata_d = ld_data;
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else if (cnt_q >= TC_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = LSU_DONE;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + TCNT_W'(1);
                if (mem_rvalid) begin
                    rdata_d = ld_data;
                    state_d = LSU_DONE;
                end else if (cnt_q >= TC_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (out_ready) begin
                    rdata_d   = 64'd0;
                    fault_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            addr_q    <= 64'd0;
            func3_q   <= 3'd0;
            we_q      <= 1'b0;
            wmask_q   <= 8'd0;
            wdata_q   <= 64'd0;
            rd_q      <= 5'd0;
            rdata_q   <= 64'd0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            func3_q   <= func3_d;
            we_q      <= we_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    assign in_ready    = (state_q == LSU_IDLE);
    assign out_valid   = (state_q == LSU_DONE);
    assign out_rdata   = rdata_q;
    assign out_rd      = rd_q;
    assign out_fault   = fault_q;
    assign out_timeout = timeout_q;

    // Memory-side outputs are quiet outside REQ so nothing stale leaks to the RAM.
    assign mem_req   = (state_q == LSU_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
    assign mem_wmask = mem_we ? wmask_q : 8'd0;
    assign mem_wdata = mem_we ? wdata_q : 64'd0;

endmodule

// File: tb/tb_ysyx_22040759_lsu.sv
// Directed bench for the LSU: store lanes, load extension, faults, watchdog,
// and reset in the middle of a load.
module tb_ysyx_22040759_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [2:0]  in_func3;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_fault, out_timeout;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040759_lsu #(.TIMEOUT_CYCLES(8), .TCNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_fault(out_fault), .out_timeout(out_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_func3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        cyc();
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_fault !== 1'b0 || out_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: valid=%b ready=%b fault=%b tmo=%b, required 0 1 0 0",
                     name, out_valid, in_ready, out_fault, out_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0 || out_fault !== 1'b0 ||
            out_timeout !== 1'b0 || out_rdata !== 64'd0 || mem_wmask !== 8'd0 || mem_addr !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b req=%b fault=%b tmo=%b rdata=%h wmask=%h addr=%h, required 1 0 0 0 0 zeros",
                     in_ready, out_valid, mem_req, out_fault, out_timeout, out_rdata, mem_wmask, mem_addr);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, input logic [63:0] exp_addr,
                              input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        issue(1'b0, 1'b1, f3, addr, wd, 5'd7);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
            mem_wmask !== exp_mask || mem_wdata !== exp_wdata) begin
            failures++;
            $display("FAIL %s_req: req=%b we=%b addr=%h mask=%h wdata=%h, required 1 1 %h %h %h",
                     name, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata, exp_addr, exp_mask, exp_wdata);
        end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b0 || out_rdata !== 64'd0 ||
            out_rd !== 5'd7 || mem_req !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: valid=%b fault=%b rdata=%h rd=%0d req=%b ready=%b, required 1 0 0 7 0 0",
                     name, out_valid, out_fault, out_rdata, out_rd, mem_req, in_ready);
        end
        consume(name);
    endtask

    task automatic test_store_lanes();
        test_store("sb", 3'b000, 64'h8000_0005, 64'hAB, 64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000);
        test_store("sh", 3'b001, 64'h8000_000A, 64'hBEEF, 64'h8000_0008, 8'h0C, 64'h0000_0000_BEEF_0000);
        test_store("sw", 3'b010, 64'h8000_0004, 64'h1122_3344_AABB_CCDD, 64'h8000_0000, 8'hF0, 64'hAABB_CCDD_0000_0000);
        test_store("sd", 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_load_wait(input string name, input logic [2:0] f3, input logic [63:0] exp);
        issue(1'b1, 1'b0, f3, 64'h8000_0006, 64'd0, 5'd3);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h8000_0000 || mem_wmask !== 8'h00) begin
            failures++;
            $display("FAIL %s_req: req=%b we=%b addr=%h mask=%h, required 1 0 80000000 00",
                     name, mem_req, mem_we, mem_addr, mem_wmask);
        end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h8001_0000_0000_0000;
        checks++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait: valid=%b req=%b, required 0 0", name, out_valid, mem_req);
        end
        cyc();
        mem_rvalid = 1'b0;
        mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== exp || out_rd !== 5'd3 || out_fault !== 1'b0) begin
            failures++;
            $display("FAIL %s_data: valid=%b rdata=%h rd=%0d fault=%b, required 1 %h 3 0",
                     name, out_valid, out_rdata, out_rd, out_fault, exp);
        end
        consume(name);
    endtask

    task automatic test_fault_hold();
        int req_seen = 0;
        issue(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            if (mem_req) req_seen++;
            checks++;
            if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_rdata !== 64'd0 || out_timeout !== 1'b0) begin
                failures++;
                $display("FAIL lw_misalign_hold%0d: valid=%b fault=%b rdata=%h tmo=%b, required 1 1 0 0",
                         i, out_valid, out_fault, out_rdata, out_timeout);
            end
            cyc();
        end
        checks++;
        if (req_seen !== 0) begin
            failures++;
            $display("FAIL lw_misalign_noreq: mem_req seen %0d cycles, required 0", req_seen);
        end
        consume("lw_misalign");
    endtask

    task automatic test_fault_kinds();
        logic [2:0]  f3s  [4] = '{3'b111, 3'b100, 3'b000, 3'b011};
        logic        rens [4] = '{1'b1,   1'b0,   1'b1,   1'b0};
        logic        wens [4] = '{1'b0,   1'b1,   1'b1,   1'b1};
        logic [63:0] adrs [4] = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0000, 64'h8000_0004};
        for (int i = 0; i < 4; i++) begin
            issue(rens[i], wens[i], f3s[i], adrs[i], 64'hFFFF, 5'd1);
            checks++;
            if (out_valid !== 1'b1 || out_fault !== 1'b1 || mem_req !== 1'b0 || out_rdata !== 64'd0) begin
                failures++;
                $display("FAIL fault_kind%0d: valid=%b fault=%b req=%b rdata=%h, required 1 1 0 0",
                         i, out_valid, out_fault, mem_req, out_rdata);
            end
            consume("fault_kind");
        end
        // neither ren nor wen: completes with no fault and no memory traffic
        issue(1'b0, 1'b0, 3'b010, 64'h8000_0003, 64'd0, 5'd2);
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b0 || mem_req !== 1'b0 || out_rdata !== 64'd0) begin
            failures++;
            $display("FAIL nop_access: valid=%b fault=%b req=%b rdata=%h, required 1 0 0 0",
                     out_valid, out_fault, mem_req, out_rdata);
        end
        consume("nop_access");
    endtask

    task automatic test_ld_same_cycle();
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, 5'd12);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0008) begin
            failures++;
            $display("FAIL ld_req: req=%b addr=%h, required 1 80000008", mem_req, mem_addr);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== 64'h1122_3344_5566_7788 || out_rd !== 5'd12) begin
            failures++;
            $display("FAIL ld_same_cycle: valid=%b rdata=%h rd=%0d, required 1 1122334455667788 12",
                     out_valid, out_rdata, out_rd);
        end
        consume("ld_same_cycle");
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b1, 1'b0, 3'b010, 64'h8000_0010, 64'd0, 5'd4);
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL timeout_req_cycles: got %0d, required 8", n);
        end
        checks++;
        if (out_valid !== 1'b1 || out_timeout !== 1'b1 || out_fault !== 1'b0 ||
            out_rdata !== 64'd0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_done: valid=%b tmo=%b fault=%b rdata=%h req=%b, required 1 1 0 0 0",
                     out_valid, out_timeout, out_fault, out_rdata, mem_req);
        end
        consume("timeout");
    endtask

    task automatic test_reset_in_wait();
        issue(1'b1, 1'b0, 3'b000, 64'h8000_0001, 64'd0, 5'd5);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_wait: ready=%b valid=%b req=%b, required 1 0 0", in_ready, out_valid, mem_req);
        end
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_AA00;
        cyc();
        mem_rvalid = 1'b0;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0 || out_rdata !== 64'd0) begin
            failures++;
            $display("FAIL late_rvalid: ready=%b valid=%b req=%b rdata=%h, required 1 0 0 0",
                     in_ready, out_valid, mem_req, out_rdata);
        end
    endtask

    task automatic test_back_to_back();
        // a request held valid while DONE must not be taken until the result is consumed
        issue(1'b0, 1'b1, 3'b000, 64'h8000_0000, 64'h55, 5'd1);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        in_valid = 1'b1; in_wen = 1'b1; in_func3 = 3'b000; in_addr = 64'h8000_0003; in_wdata = 64'h66;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: ready=%b req=%b valid=%b, required 1 0 0", in_ready, mem_req, out_valid);
        end
        cyc();
        in_valid = 1'b0; in_wen = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_wmask !== 8'h08 || mem_wdata !== 64'h0000_0000_6600_0000) begin
            failures++;
            $display("FAIL b2b_second: req=%b mask=%h wdata=%h, required 1 08 0000000066000000",
                     mem_req, mem_wmask, mem_wdata);
        end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        consume("b2b");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_func3 = 3'd0;
        in_addr = 64'd0; in_wdata = 64'd0; in_rd = 5'd0; out_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        test_reset();
        test_store_lanes();
        test_load_wait("lh",  3'b001, 64'hFFFF_FFFF_FFFF_8001);
        test_load_wait("lhu", 3'b101, 64'h0000_0000_0000_8001);
        test_fault_hold();
        test_fault_kinds();
        test_ld_same_cycle();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22040759_lsu.md
Name: ysyx_22040759_lsu

Overview:
- Multi-cycle load/store unit between the EX/MEM pipeline register and the data-memory port; sits directly upstream of the data RAM.
- Accepts one RV64 load or store per handshake and drives an 8-byte-aligned, byte-masked memory request. For loads, it extracts and sign/zero-extends the addressed field before returning the result to write-back.
- Detects misaligned accesses and illegal func3 values and flags them instead of touching memory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access is abandoned with out_timeout.
- TCNT_W, 8: width of the watchdog counter; must satisfy 2^TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  LSU can accept a request; equals (state==IDLE).
- in_ren  in  1  load request.
- in_wen  in  1  store request; in_ren and in_wen both high is a fault.
- in_func3  in  3  RISC-V funct3 of the load/store.
- in_addr  in  64  effective byte address.
- in_wdata  in  64  store data, right-aligned.
- in_rd  in  5  destination register tag; passed through to out_rd.
- out_valid  out  1  result valid to write-back.
- out_ready  in  1  write-back accepts the result.
- out_rdata  out  64  extended load data; 0 for stores and faults.
- out_rd  out  5  latched in_rd.
- out_fault  out  1  misaligned access, illegal func3, or ren&wen.
- out_timeout  out  1  watchdog expired.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  64  {addr[63:3],3'b000}.
- mem_wdata  out  64  lane-shifted store data.
- mem_wmask  out  8  byte-lane enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  64  aligned 8-byte read data.

Behaviour:
- Reset: state=IDLE; all outputs 0 except in_ready=1; counter=0. Reset mid-transaction abandons the access: mem_req is 0 after the edge and no result is produced.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on in_valid&in_ready, latch in_* and off=in_addr[2:0].
  - If fault → DONE with out_fault=1, no mem_req.
  - Else if neither ren nor wen → DONE with rdata=0.
  - Else → REQ.
- Fault conditions:
  - Load func3 ∈ {000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU}; 111 is illegal.
  - Store func3 ∈ {000..011}; 1xx is illegal.
  - Misalignment: H needs off[0]=0, W needs off[1:0]=0, D needs off=0.
- REQ: mem_req=1 with stable mem_we/addr/wdata/wmask until mem_gnt.
  - Store with gnt → DONE.
  - Load with gnt → WAIT, unless mem_rvalid is also high that cycle, in which case capture and go to DONE.
- WAIT: on mem_rvalid, capture extracted data → DONE. mem_rvalid in IDLE, REQ-without-gnt, or DONE is ignored.
- Watchdog:
  - Counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES, go to DONE with out_timeout=1, out_rdata=0, and mem_req low.
- DONE: out_valid=1 and outputs held stable until out_ready; then → IDLE, out_valid=0, flags cleared. No new request is accepted in the same cycle; minimum issue interval is therefore 3 cycles for stores and 4 for loads when gnt/rvalid are immediate.
- Store lanes: size mask m = 01/03/0F/FF for func3 000/001/010/011. mem_wmask = m<<off; mem_wdata = in_wdata<<(8*off), truncated to 64 bits.
- Load extract: s = mem_rdata>>(8*off), then:
  - LB, LH, LW: sign-extend bits 7, 15, 31.
  - LBU, LHU, LWU: zero-extend.
  - LD: s unchanged.
- Fault and timeout are mutually exclusive; both are reported through the normal out_valid handshake.

Decomposition:
- Shared package ysyx_22040759_define gains:
  - func3 constants for LB..LWU and SB..SD.
  - LSU state encoding (2-bit).
  - Size-mask constants.
- One natural sub-module: ysyx_22040759_lsu_align. It is purely combinational and produces wmask/wdata/misalign from func3, off and wdata, and the extended load result from func3, off and rdata. The LSU top holds the FSM, latches and watchdog.

Test Plan:
- SB addr=0x80000005, wdata=0xAB, gnt next cycle → mem_addr=0x80000000, wmask=0x20, mem_wdata[47:40]=0xAB; out_valid with out_fault=0.
- LH addr=0x80000006, mem_rdata=0x8001_0000_0000_0000 with rvalid 2 cycles after gnt → out_rdata=0xFFFFFFFFFFFF8001. The same access with LHU → 0x8001.
- LW addr=0x80000002 → out_fault=1, mem_req never asserted, out_rdata=0; result held 3 cycles with out_ready=0, then consumed.
- LD addr=0x80000008 with gnt and rvalid in the same cycle → DONE next cycle, out_rdata=mem_rdata; func3=111 load → fault.
- Load with gnt never asserted, TIMEOUT_CYCLES=8 → out_timeout=1 after 8 REQ cycles and mem_req drops.
- rst pulsed while in WAIT → next cycle in_ready=1, out_valid=0, mem_req=0; a late mem_rvalid is ignored.
